mlp_neuron_engine: RTL and testbench

- Parametrised successor of the single-shot MLP compute datapath. Computes one neuron per transaction: streams K beats of N_LANES input/weight pairs, accumulates them with saturation, adds bias, applies a selectable activation and requantises to the data format.
- Sits between the layer sequencer (weight/activation buffers) and the output activation buffer.
- Uses valid/ready handshakes on both sides in place of the enable/clear pulses.

---
 rtl/fixed_point_pkg.sv | 20 ++
 rtl/mlp_lane_product_tree.sv | 37 +++
 rtl/mlp_neuron_engine.sv | 110 +++++++++++
 tb/tb_mlp_neuron_engine.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg: shared enums and signed fixed-point helpers for the neuron engine.
package fixed_point_pkg;

    typedef enum logic [1:0] {ACT_RELU, ACT_LEAKY, ACT_CLAMP, ACT_IDENT} act_type_e;
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_HOLD} state_e;

    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return v > hi ? hi : v < lo ? lo : v;
    endfunction

    // Round half up, then arithmetic shift right.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] v, input int sh);
        return sh == 0 ? v : (v + (64'sd1 <<< (sh - 1))) >>> sh;
    endfunction

endpackage

// File: rtl/mlp_lane_product_tree.sv
// mlp_lane_product_tree: registered lane multipliers followed by a registered lane adder tree.
module mlp_lane_product_tree #(
    parameter int N_LANES = 8,
    parameter int DATA_W  = 8,
    parameter int SUM_W   = 2 * DATA_W + $clog2(N_LANES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_LANES*DATA_W-1:0]   data_i,
    input  logic [N_LANES*DATA_W-1:0]   weight_i,
    output logic signed [SUM_W-1:0]     sum_o
);

    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0]    prod_d [N_LANES];
    logic signed [PW-1:0]    prod_q [N_LANES];
    logic signed [SUM_W-1:0] sum_d;
    logic signed [SUM_W-1:0] sum_q;

    assign sum_o = sum_q;

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N_LANES; i++) begin
            prod_d[i] = PW'($signed(data_i[i*DATA_W +: DATA_W])) * PW'($signed(weight_i[i*DATA_W +: DATA_W]));
            sum_d     = sum_d + SUM_W'(prod_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_LANES; i++)
            prod_q[i] <= rst_n ? prod_d[i] : '0;
        sum_q <= rst_n ? sum_d : '0;
    end

endmodule

// File: rtl/mlp_neuron_engine.sv
// mlp_neuron_engine: streams K beats per neuron, saturating accumulate, bias, activation and requantise.
module mlp_neuron_engine
    import fixed_point_pkg::*;
#(
    parameter int N_LANES     = 8,
    parameter int DATA_W      = 8,
    parameter int FRAC_BITS   = 4,
    parameter int ACC_W       = 24,
    parameter int LEAKY_SHIFT = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_last,
    input  logic [N_LANES*DATA_W-1:0] data_in,
    input  logic [N_LANES*DATA_W-1:0] weight_in,
    input  logic [DATA_W-1:0]         bias_in,
    input  logic [1:0]                act_type,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         result_out,
    output logic [ACC_W-1:0]          acc_out,
    output logic                      acc_sat
);

    localparam int SUM_W = 2 * DATA_W + $clog2(N_LANES);
    localparam logic signed [63:0] ONE = 64'sd1 <<< (2 * FRAC_BITS);

    state_e                  state_q, state_d;
    act_type_e               act_q;
    logic                    accept, first;
    logic                    v1_q, f1_q, l1_q, v2_q, f2_q, l2_q, done_q;
    logic                    sat_q, sat_d;
    logic signed [SUM_W-1:0] sum;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [DATA_W-1:0] bias_q, res_q, res_d;
    logic signed [63:0]      raw, pre, act_v;

    assign in_ready   = state_q == S_IDLE || state_q == S_ACCUM;
    assign accept     = in_valid && in_ready;
    assign first      = accept && state_q == S_IDLE;
    assign out_valid  = state_q == S_HOLD;
    assign result_out = res_q;
    assign acc_out    = acc_q;
    assign acc_sat    = sat_q;

    mlp_lane_product_tree #(.N_LANES(N_LANES), .DATA_W(DATA_W), .SUM_W(SUM_W)) u_tree (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_i   (data_in),
        .weight_i (weight_in),
        .sum_o    (sum)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = accept ? (in_last ? S_DRAIN : S_ACCUM) : S_IDLE;
            S_ACCUM: state_d = accept && in_last ? S_DRAIN : S_ACCUM;
            S_DRAIN: state_d = done_q ? S_HOLD : S_DRAIN;
            S_HOLD:  state_d = out_ready ? S_IDLE : S_HOLD;
            default: state_d = S_IDLE;
        endcase
    end

    // The first beat's tag zeroes the accumulator and restarts the sticky flag.
    always_comb begin
        raw   = (f2_q ? 64'sd0 : 64'(acc_q)) + 64'(sum);
        acc_d = ACC_W'(sat_s(raw, ACC_W));
        sat_d = (64'(acc_d) != raw) || (!f2_q && sat_q);
        pre   = sat_s(64'(acc_q) + (64'(bias_q) <<< FRAC_BITS), ACC_W);
        act_v = act_q == ACT_RELU  ? (pre < 0 ? 64'sd0 : pre) :
                act_q == ACT_LEAKY ? (pre < 0 ? pre >>> LEAKY_SHIFT : pre) :
                act_q == ACT_CLAMP ? (pre < 0 ? 64'sd0 : pre > ONE ? ONE : pre) : pre;
        res_d = DATA_W'(sat_s(round_shift(act_v, FRAC_BITS), DATA_W));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            {v1_q, f1_q, l1_q, v2_q, f2_q, l2_q, done_q} <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            bias_q  <= '0;
            act_q   <= ACT_RELU;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            v1_q    <= accept;
            f1_q    <= first;
            l1_q    <= in_last;
            v2_q    <= v1_q;
            f2_q    <= f1_q;
            l2_q    <= l1_q;
            done_q  <= v2_q && l2_q;
            if (v2_q) begin
                acc_q <= acc_d;
                sat_q <= sat_d;
            end
            if (first) begin
                bias_q <= $signed(bias_in);
                act_q  <= act_type_e'(act_type);
            end
            if (done_q)
                res_q <= res_d;
        end
    end

endmodule

// File: tb/tb_mlp_neuron_engine.sv
// tb_mlp_neuron_engine: directed table-driven checks plus hold, same-cycle handshake, saturation and reset sequences.
module tb_mlp_neuron_engine;

    localparam int N  = 8;
    localparam int DW = 8;

    typedef struct {
        logic [7:0] d;
        logic [7:0] w;
        logic [7:0] b;
        logic [1:0] act;
        int         beats;
        logic [7:0] res;
        longint     acc;
        bit         sat;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [N*DW-1:0] data_in = '0, weight_in = '0;
    logic [7:0]    bias_in = '0;
    logic [1:0]    act_type = '0;
    logic          in_ready, out_valid, acc_sat;
    logic [7:0]    result_out;
    logic [23:0]   acc_out;
    logic          in_ready12, out_valid12, acc_sat12;
    logic [7:0]    result12;
    logic [11:0]   acc12;

    int n_cmp = 0;
    int n_fail = 0;
    int lat;
    vec_t vecs [10];

    always #5 clk = ~clk;

    mlp_neuron_engine dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .data_in(data_in), .weight_in(weight_in), .bias_in(bias_in), .act_type(act_type),
        .out_valid(out_valid), .out_ready(out_ready), .result_out(result_out),
        .acc_out(acc_out), .acc_sat(acc_sat)
    );

    mlp_neuron_engine #(.ACC_W(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready12), .in_last(in_last),
        .data_in(data_in), .weight_in(weight_in), .bias_in(bias_in), .act_type(act_type),
        .out_valid(out_valid12), .out_ready(out_ready), .result_out(result12),
        .acc_out(acc12), .acc_sat(acc_sat12)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beats(input logic [7:0] d, input logic [7:0] w, input logic [7:0] b,
                               input logic [1:0] act, input int beats);
        for (int i = 0; i < beats; i++) begin
            in_valid  = 1'b1;
            in_last   = (i == beats - 1);
            data_in   = {N{d}};
            weight_in = {N{w}};
            bias_in   = b;
            act_type  = act;
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(output int l);
        l = 0;
        while (!out_valid && l < 20) begin
            step();
            l++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int l;
        drive_beats(v.d, v.w, v.b, v.act, v.beats);
        wait_out(l);
        chk({tag, "_latency"}, l, 3);
        chk({tag, "_result"}, result_out, v.res);
        chk({tag, "_acc"}, $signed(acc_out), v.acc);
        chk({tag, "_sat"}, acc_sat, v.sat);
        take();
        chk({tag, "_ready_after"}, in_ready, 1);
    endtask

    initial begin
        vecs[0] = '{8'h08, 8'h10, 8'h00, 2'd0, 1, 8'h40, 1024, 1'b0};
        vecs[1] = '{8'h08, 8'h10, 8'h10, 2'd0, 1, 8'h50, 1024, 1'b0};
        vecs[2] = '{8'h10, 8'hF0, 8'h00, 2'd0, 1, 8'h00, -2048, 1'b0};
        vecs[3] = '{8'h10, 8'hF0, 8'h00, 2'd3, 1, 8'h80, -2048, 1'b0};
        vecs[4] = '{8'h10, 8'hF0, 8'h00, 2'd1, 1, 8'hF0, -2048, 1'b0};
        vecs[5] = '{8'h10, 8'hF0, 8'h00, 2'd2, 1, 8'h00, -2048, 1'b0};
        vecs[6] = '{8'h10, 8'h10, 8'h00, 2'd0, 2, 8'h7F, 4096, 1'b0};
        vecs[7] = '{8'h10, 8'h10, 8'h00, 2'd2, 2, 8'h10, 4096, 1'b0};
        vecs[8] = '{8'h08, 8'h10, 8'hF0, 2'd3, 1, 8'h30, 1024, 1'b0};
        vecs[9] = '{8'h08, 8'h10, 8'h00, 2'd1, 1, 8'h40, 1024, 1'b0};

        repeat (2) step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result_out, 0);
        chk("rst_acc", acc_out, 0);
        chk("rst_sat", acc_sat, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++)
            run_vec(vecs[i], $sformatf("v%0d", i));

        // ACC_W=12 instance saturates on the first 2048 product sum
        drive_beats(8'h10, 8'h10, 8'h00, 2'd0, 2);
        wait_out(lat);
        chk("sat12_valid", out_valid12, 1);
        chk("sat12_flag", acc_sat12, 1);
        chk("sat12_acc", $signed(acc12), 2047);
        chk("sat12_result", result12, 8'h7F);
        chk("sat24_flag", acc_sat, 0);
        take();

        // Hold with out_ready low while extra beats are offered
        drive_beats(8'h08, 8'h10, 8'h00, 2'd0, 1);
        wait_out(lat);
        for (int c = 0; c < 5; c++) begin
            in_valid  = 1'b1;
            in_last   = 1'b1;
            data_in   = {N{8'h10}};
            weight_in = {N{8'h10}};
            step();
            chk($sformatf("hold%0d_result", c), result_out, 8'h40);
            chk($sformatf("hold%0d_in_ready", c), in_ready, 0);
            chk($sformatf("hold%0d_out_valid", c), out_valid, 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        take();
        chk("hold_release_ready", in_ready, 1);
        chk("hold_release_valid", out_valid, 0);
        run_vec(vecs[0], "after_hold");

        // Consumer ready before the result appears: transfer on the first valid edge
        out_ready = 1'b1;
        drive_beats(8'h08, 8'h10, 8'h10, 2'd0, 1);
        wait_out(lat);
        chk("same_cycle_latency", lat, 3);
        chk("same_cycle_result", result_out, 8'h50);
        step();
        chk("same_cycle_valid_drop", out_valid, 0);
        chk("same_cycle_ready", in_ready, 1);
        out_ready = 1'b0;

        // Reset mid-neuron after 2 of 4 beats
        in_valid  = 1'b1;
        in_last   = 1'b0;
        data_in   = {N{8'h10}};
        weight_in = {N{8'h10}};
        step();
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("mid_acc_nonzero", acc_out, 4096);
        chk("mid_in_ready", in_ready, 1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_acc", acc_out, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_result", result_out, 0);
        chk("mid_rst_sat", acc_sat, 0);
        chk("mid_rst_ready", in_ready, 1);
        rst_n = 1'b1;
        step();
        run_vec(vecs[0], "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
